// File: rtl/wb_rstgen.sv
// Wishbone SYSCON reset generator: async-assert/sync-release reset, stretched sync reset,
// software reset and optional watchdog (define WB_RSTGEN_WDOG_EN to include the watchdog).
module wb_rstgen #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 4,
    parameter int WDOG_TIMEOUT   = 1024
) (
    input  logic       clk_i,
    input  logic       async_rst_i,
    input  logic       sw_rst_req_i,
`ifdef WB_RSTGEN_WDOG_EN
    input  logic       wdog_kick_i,
`endif
    output logic       async_rst_o,
    output logic       sync_rst_o,
    output logic [1:0] rst_cause_o
);

    typedef enum logic [1:0] {SYNC, STRETCH, RUN} state_t;

    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;
    localparam logic [7:0] STRETCH_LD = 8'(STRETCH_CYCLES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("wb_rstgen: SYNC_STAGES out of range 2..4");
    end
    if (STRETCH_CYCLES < 1 || STRETCH_CYCLES > 255) begin : g_bad_stretch
        $error("wb_rstgen: STRETCH_CYCLES out of range 1..255");
    end
    if (WDOG_TIMEOUT < 2 || WDOG_TIMEOUT > 65535) begin : g_bad_wdog
        $error("wb_rstgen: WDOG_TIMEOUT out of range 2..65535");
    end

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             cnt_q, cnt_d;
    logic [1:0]             cause_d;
    logic                   wd_expire;

    // A 1 walks through the chain; the reset releases once it reaches the last flop.
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) sync_q <= '0;
        else              sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign async_rst_o = ~sync_q[SYNC_STAGES-1];
    assign sync_rst_o  = (state_q != RUN);

`ifdef WB_RSTGEN_WDOG_EN
    localparam logic [15:0] WDOG_LD = 16'(WDOG_TIMEOUT);
    logic [15:0] wd_q;

    assign wd_expire = (state_q == RUN) && !wdog_kick_i && (wd_q == 16'd1);

    // Counter reads WDOG_TIMEOUT throughout SYNC/STRETCH, so every RUN starts with a full period.
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i)
            wd_q <= WDOG_LD;
        else if (state_q != RUN || state_d != RUN || wdog_kick_i)
            wd_q <= WDOG_LD;
        else
            wd_q <= wd_q - 16'd1;
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q     <= SYNC;
            cnt_q       <= '0;
            rst_cause_o <= CAUSE_EXT;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_cause_o <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = rst_cause_o;
        case (state_q)
            SYNC: begin
                // Leave SYNC on the same edge that drops async_rst_o.
                if (sync_q[SYNC_STAGES-2]) begin
                    state_d = STRETCH;
                    cnt_d   = STRETCH_LD;
                end
            end
            STRETCH: begin
                if (sw_rst_req_i) begin
                    cnt_d   = STRETCH_LD;
                    cause_d = CAUSE_SW;
                end else if (cnt_q <= 8'd1) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RUN: begin
                // Software request takes priority over a simultaneous watchdog expiry.
                if (sw_rst_req_i) begin
                    state_d = STRETCH;
                    cnt_d   = STRETCH_LD;
                    cause_d = CAUSE_SW;
                end else if (wd_expire) begin
                    state_d = STRETCH;
                    cnt_d   = STRETCH_LD;
                    cause_d = CAUSE_WDOG;
                end
            end
            default: state_d = SYNC;
        endcase
    end

endmodule

// File: tb/tb_wb_rstgen.sv
// Directed bench for wb_rstgen: vector table for power-on/software/retrigger behaviour,
// hand sequences for async reset mid-stretch and (with WB_RSTGEN_WDOG_EN) the watchdog.
module tb_wb_rstgen;

    logic       clk = 1'b0;
    logic       async_rst = 1'b0;
    logic       sw = 1'b0;
    logic       ao, so;
    logic [1:0] cause;
`ifdef WB_RSTGEN_WDOG_EN
    logic       kick = 1'b0;
`endif

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    wb_rstgen #(.SYNC_STAGES(2), .STRETCH_CYCLES(4), .WDOG_TIMEOUT(8)) dut (
        .clk_i       (clk),
        .async_rst_i (async_rst),
        .sw_rst_req_i(sw),
`ifdef WB_RSTGEN_WDOG_EN
        .wdog_kick_i (kick),
`endif
        .async_rst_o (ao),
        .sync_rst_o  (so),
        .rst_cause_o (cause)
    );

    typedef struct {
        logic       a;
        logic       s;
        logic       ea;
        logic       es;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic s);
        @(negedge clk);
        async_rst = a;
        sw        = s;
`ifdef WB_RSTGEN_WDOG_EN
        kick      = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

`ifdef WB_RSTGEN_WDOG_EN
    task automatic stepk(input logic s, input logic k);
        @(negedge clk);
        async_rst = 1'b1;
        sw        = s;
        kick      = k;
        @(posedge clk);
        #1;
    endtask
`endif

    function automatic void push(input logic a, s, ea, es, input logic [1:0] ec);
        vec_t v;
        v.a = a; v.s = s; v.ea = ea; v.es = es; v.ec = ec;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic seen;

        // edge-by-edge table; expected values are the outputs after that edge
        repeat (3) push(0, 0, 1, 1, 2'b00);           // power-on reset held
        push(1, 0, 1, 1, 2'b00);                      // edge 1: sync chain 01
        push(1, 0, 0, 1, 2'b00);                      // edge 2: async_rst_o falls
        push(1, 0, 0, 1, 2'b00);
        push(1, 0, 0, 1, 2'b00);
        push(1, 0, 0, 1, 2'b00);
        push(1, 0, 0, 0, 2'b00);                      // edge 6: sync_rst_o falls
        push(1, 0, 0, 0, 2'b00);
        push(1, 1, 0, 1, 2'b01);                      // software pulse
        repeat (3) push(1, 0, 0, 1, 2'b01);
        push(1, 0, 0, 0, 2'b01);                      // 4 cycles high
        push(1, 0, 0, 0, 2'b01);
        push(1, 1, 0, 1, 2'b01);                      // retrigger sequence
        push(1, 0, 0, 1, 2'b01);
        push(1, 1, 0, 1, 2'b01);                      // second pulse 2 cycles in
        repeat (3) push(1, 0, 0, 1, 2'b01);
        push(1, 0, 0, 0, 2'b01);                      // 6 cycles high total
        push(0, 0, 1, 1, 2'b00);                      // external reset clears cause
        push(1, 1, 1, 1, 2'b00);                      // sw ignored in SYNC
        push(1, 1, 0, 1, 2'b00);
        repeat (3) push(1, 0, 0, 1, 2'b00);
        push(1, 0, 0, 0, 2'b00);

        #1;
        chk("reset_async_o", int'(ao), 1);
        chk("reset_sync_o", int'(so), 1);
        chk("reset_cause", int'(cause), 0);

        foreach (tbl[i]) begin
            step(tbl[i].a, tbl[i].s);
            chk($sformatf("vec%0d_async_o", i), int'(ao), int'(tbl[i].ea));
            chk($sformatf("vec%0d_sync_o", i), int'(so), int'(tbl[i].es));
            chk($sformatf("vec%0d_cause", i), int'(cause), int'(tbl[i].ec));
        end

        // async reset in the middle of a stretch, observed before any clock edge
        step(1, 1);
        chk("midstretch_enter_cause", int'(cause), 1);
        step(1, 0);
        @(negedge clk);
        async_rst = 1'b0;
        #1;
        chk("midstretch_async_o", int'(ao), 1);
        chk("midstretch_sync_o", int'(so), 1);
        chk("midstretch_cause", int'(cause), 0);
        step(0, 0);
        n = 0;
        do begin
            step(1, 0);
            n++;
        end while (so && n < 20);
        chk("release_to_run_edges", n, 6);
        chk("release_async_o", int'(ao), 0);

`ifdef WB_RSTGEN_WDOG_EN
        // no kick: expiry 8 edges after RUN entry
        n = 0;
        do begin
            stepk(0, 0);
            n++;
        end while (!so && n < 30);
        chk("wdog_expire_edges", n, 8);
        chk("wdog_cause", int'(cause), 2);
        chk("wdog_async_o", int'(ao), 0);
        repeat (3) stepk(0, 0);
        stepk(0, 0);
        chk("wdog_back_to_run", int'(so), 0);

        // kick every 7 cycles keeps RUN
        seen = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            stepk(0, (k % 7) == 0);
            if (so) seen = 1'b1;
        end
        chk("wdog_kicked_no_reset", int'(seen), 0);

        // software request on the expiry edge
        repeat (7) stepk(0, 0);
        stepk(1, 0);
        chk("collision_sw_sync_o", int'(so), 1);
        chk("collision_sw_cause", int'(cause), 1);
        repeat (3) stepk(0, 0);
        stepk(0, 0);
        chk("collision_sw_run", int'(so), 0);

        // kick on the expiry edge
        repeat (7) stepk(0, 0);
        stepk(0, 1);
        chk("collision_kick_no_reset", int'(so), 0);
        repeat (7) stepk(0, 0);
        chk("after_kick_still_run", int'(so), 0);
        stepk(0, 0);
        chk("after_kick_expire", int'(so), 1);
        chk("after_kick_cause", int'(cause), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/wb_rstgen.md
WB_RSTGEN -- requirements
Module: wb_rstgen

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of reset-release synchronizer flops (legal range 2..4).
REQ-003 Parameter STRETCH_CYCLES, default 4, SHALL set the number of cycles sync_rst_o is held after async_rst_o releases or after a request (legal range 1..255).
REQ-004 Parameter WDOG_TIMEOUT, default 1024, SHALL set the watchdog reload value in cycles (legal range 2..65535); it is used only with WB_RSTGEN_WDOG_EN.
REQ-005 Port clk_i, input, 1 bit: module clock.
REQ-006 Port async_rst_i, input, 1 bit: asynchronous reset, active-low, from board or power-on circuit.
REQ-007 Port sw_rst_req_i, input, 1 bit: software reset request, sampled on rising clk_i.
REQ-008 Port wdog_kick_i, input, 1 bit: watchdog service strobe; present only with WB_RSTGEN_WDOG_EN.
REQ-009 Port async_rst_o, output, 1 bit: active-high asynchronous reset to SYSCON consumers.
REQ-010 Port sync_rst_o, output, 1 bit: active-high synchronous reset to SYSCON consumers.
REQ-011 Port rst_cause_o, output, 2 bits: cause of the last reset (00 external, 01 software, 10 watchdog, 11 unused).

Function
REQ-012 The state machine SHALL have three states: SYNC, STRETCH and RUN.
REQ-013 async_rst_o SHALL assert asynchronously, with no clock required, whenever async_rst_i is low.
REQ-014 async_rst_o SHALL deassert only synchronously, on the SYNC_STAGES-th rising clk_i edge after async_rst_i goes high; a 1 is shifted through the synchronizer chain.
REQ-015 The block SHALL remain in SYNC while async_rst_o is high, and SHALL move to STRETCH on the edge where async_rst_o deasserts.
REQ-016 On entry to STRETCH, an 8-bit counter SHALL load STRETCH_CYCLES and decrement on each edge; at 1 the state SHALL become RUN.
REQ-017 sync_rst_o SHALL be high in SYNC and STRETCH and low only in RUN, giving a sync_rst_o low edge exactly STRETCH_CYCLES edges after the async_rst_o low edge.
REQ-018 sw_rst_req_i high in RUN SHALL, on that edge, set the state to STRETCH, reload the counter and set rst_cause_o=01; sync_rst_o SHALL be high from the next cycle and async_rst_o SHALL stay low.
REQ-019 sw_rst_req_i high during STRETCH SHALL reload the counter, restarting the stretch, and set rst_cause_o=01.
REQ-020 sw_rst_req_i SHALL be ignored in SYNC.
REQ-021 async_rst_i going low in any state, including mid-STRETCH, SHALL force SYNC immediately and set rst_cause_o=00.
REQ-022 If a software request and watchdog expiry occur on the same edge, rst_cause_o SHALL be 01.

Reset
REQ-023 While async_rst_i is low, the block SHALL hold: state=SYNC, synchronizer=all 0, counter=0, async_rst_o=1, sync_rst_o=1, rst_cause_o=00, watchdog counter=WDOG_TIMEOUT.
REQ-024 rst_cause_o SHALL NOT be cleared by software or watchdog resets; it changes only per REQ-018, REQ-019, REQ-021 and REQ-028.

Configuration
REQ-025 Macro WB_RSTGEN_WDOG_EN SHALL include the watchdog and the wdog_kick_i port.
REQ-026 With WB_RSTGEN_WDOG_EN, a 16-bit watchdog counter SHALL decrement each RUN cycle and SHALL be held at WDOG_TIMEOUT in SYNC and STRETCH.
REQ-027 With WB_RSTGEN_WDOG_EN, wdog_kick_i high in RUN SHALL reload WDOG_TIMEOUT; a kick wins over expiry on the same edge.
REQ-028 With WB_RSTGEN_WDOG_EN, a counter value of 1 in RUN with no kick SHALL cause entry to STRETCH and set rst_cause_o=10.
REQ-029 Without WB_RSTGEN_WDOG_EN, the watchdog logic and port SHALL be absent, and rst_cause_o=10 SHALL never occur.

Verification
REQ-030 Power-on: async_rst_i low for 3 cycles, then high with defaults -> async_rst_o falls at edge 2, sync_rst_o falls at edge 6, rst_cause_o=00.
REQ-031 Software reset: sw_rst_req_i pulsed 1 cycle in RUN -> sync_rst_o high for exactly 4 cycles, async_rst_o stays 0, rst_cause_o=01.
REQ-032 Retrigger: second sw_rst_req_i pulse 2 cycles into STRETCH -> sync_rst_o high 6 cycles total.
REQ-033 Mid-operation reset: async_rst_i low mid-STRETCH -> async_rst_o=1 with no clock edge, state SYNC, rst_cause_o=00.
REQ-034 Watchdog (macro on, WDOG_TIMEOUT=8): no kick -> STRETCH entered 8 cycles after RUN, rst_cause_o=10; kick every 7 cycles -> no reset.
REQ-035 Collision (macro on): sw_rst_req_i on the expiry edge -> rst_cause_o=01; wdog_kick_i on the expiry edge -> no reset.
